// File: rtl/mem_pkg.sv
// Shared uop codes, FSM state constants and memory-access helpers for mem_writeback.
package mem_pkg;

  // Execute-stage groups 000/001/010 are ALU ops that write RD1 back; 011 is branch.
  localparam logic [2:0] GRP_BRANCH = 3'b011;
  localparam logic [2:0] GRP_LOAD   = 3'b101;
  localparam logic [2:0] GRP_STORE  = 3'b110;

  localparam logic [5:0] UOP_LB  = 6'b101_000;
  localparam logic [5:0] UOP_LH  = 6'b101_001;
  localparam logic [5:0] UOP_LW  = 6'b101_010;
  localparam logic [5:0] UOP_LBU = 6'b101_100;
  localparam logic [5:0] UOP_LHU = 6'b101_101;
  localparam logic [5:0] UOP_SB  = 6'b110_000;
  localparam logic [5:0] UOP_SH  = 6'b110_001;
  localparam logic [5:0] UOP_SW  = 6'b110_010;

  // Access size lives in the low two bits of every memory uop.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  function automatic logic is_load(input logic [5:0] uop);
    return (uop == UOP_LB) || (uop == UOP_LH) || (uop == UOP_LW) ||
           (uop == UOP_LBU) || (uop == UOP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] uop);
    return (uop == UOP_SB) || (uop == UOP_SH) || (uop == UOP_SW);
  endfunction

  function automatic logic is_alu(input logic [5:0] uop);
    return uop[5:3] < GRP_BRANCH;
  endfunction

  function automatic logic misaligned(input logic [5:0] uop, input logic [1:0] lo);
    return ((uop[1:0] == SZ_H) && lo[0]) || ((uop[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

  function automatic logic [3:0] byte_en(input logic [5:0] uop, input logic [1:0] lo);
    case (uop[1:0])
      SZ_B:    return 4'b0001 << lo;
      SZ_H:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_writeback_load_align.sv
// Load lane select and sign/zero extension for mem_writeback.
module load_align
  import mem_pkg::*;
#(
  parameter int W_PD_DATA = 32,
  parameter int W_PD_UOPS = 6
) (
  input  logic [W_PD_DATA-1:0] rdata,
  input  logic [1:0]           addr_lo,
  input  logic [W_PD_UOPS-1:0] uop,
  output logic [W_PD_DATA-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;

  always_comb begin
    case (addr_lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    // LBU/LHU carry bit 2 set; everything else in the load group sign-extends.
    sx = (uop[5:3] == GRP_LOAD) && !uop[2];
    case (uop[1:0])
      SZ_B:    data = {{(W_PD_DATA-8){sx & b[7]}}, b};
      SZ_H:    data = {{(W_PD_DATA-16){sx & h[15]}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_writeback.sv
// Memory/writeback stage: load/store over req/ack, register writeback, upstream stall.
// Optional MEM_MISALIGN_TRAP_EN adds DFO_exc/DFO_exc_addr and suppresses misaligned accesses.
//
// state | meaning
// IDLE  | accepting uops; non-memory uops retire in one cycle
// BUSY  | memory request outstanding, upstream stalled until DMI_ack
module mem_writeback
  import mem_pkg::*;
#(
  parameter int W_PD_DATA = 32,
  parameter int W_AA_DATA = 32,
  parameter int W_PD_UOPS = 6,
  parameter int W_RD_IDX  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 DFI_valid,
  output logic                 DFO_ready,
  input  logic [W_PD_UOPS-1:0] DFI_PD_uops,
  input  logic [W_PD_DATA-1:0] DFI_PD_RD1,
  input  logic [W_PD_DATA-1:0] DFI_PD_rt,
  input  logic [W_RD_IDX-1:0]  DFI_RD_idx,
  output logic                 DMO_req,
  output logic                 DMO_we,
  output logic [W_AA_DATA-1:0] DMO_addr,
  output logic [3:0]           DMO_be,
  output logic [W_PD_DATA-1:0] DMO_wdata,
  input  logic                 DMI_ack,
  input  logic [W_PD_DATA-1:0] DMI_rdata,
  output logic                 DFO_WB_en,
  output logic [W_RD_IDX-1:0]  DFO_WB_idx,
  output logic [W_PD_DATA-1:0] DFO_WB_data
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                 DFO_exc,
  output logic [W_AA_DATA-1:0] DFO_exc_addr
`endif
);

  logic [0:0]           state;
  logic [W_PD_UOPS-1:0] uop_q;
  logic [1:0]           lo_q;
  logic [W_RD_IDX-1:0]  idx_q;
  logic [W_PD_DATA-1:0] ld_data;
  logic [W_PD_DATA-1:0] st_wdata;
  logic                 xfer, mem_op, misal;

  assign DFO_ready = (state == IDLE);
  assign xfer      = DFI_valid & DFO_ready;
  assign mem_op    = is_load(DFI_PD_uops) | is_store(DFI_PD_uops);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misal = misaligned(DFI_PD_uops, DFI_PD_RD1[1:0]);
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    case (DFI_PD_uops[1:0])
      SZ_B:    st_wdata = {4{DFI_PD_rt[7:0]}};
      SZ_H:    st_wdata = {2{DFI_PD_rt[15:0]}};
      default: st_wdata = DFI_PD_rt;
    endcase
  end

  load_align #(.W_PD_DATA(W_PD_DATA), .W_PD_UOPS(W_PD_UOPS)) u_load_align (
    .rdata   (DMI_rdata),
    .addr_lo (lo_q),
    .uop     (uop_q),
    .data    (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      DMO_req     <= 1'b0;
      DMO_we      <= 1'b0;
      DMO_addr    <= '0;
      DMO_be      <= '0;
      DMO_wdata   <= '0;
      DFO_WB_en   <= 1'b0;
      DFO_WB_idx  <= '0;
      DFO_WB_data <= '0;
      uop_q       <= '0;
      lo_q        <= '0;
      idx_q       <= '0;
    end else begin
      DFO_WB_en <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer && mem_op && !misal) begin
            state     <= BUSY;
            DMO_req   <= 1'b1;
            DMO_we    <= is_store(DFI_PD_uops);
            DMO_addr  <= {DFI_PD_RD1[W_AA_DATA-1:2], 2'b00};
            DMO_be    <= byte_en(DFI_PD_uops, DFI_PD_RD1[1:0]);
            DMO_wdata <= is_store(DFI_PD_uops) ? st_wdata : '0;
            uop_q     <= DFI_PD_uops;
            lo_q      <= DFI_PD_RD1[1:0];
            idx_q     <= DFI_RD_idx;
          end else if (xfer && is_alu(DFI_PD_uops)) begin
            DFO_WB_en   <= (DFI_RD_idx != '0);
            DFO_WB_idx  <= DFI_RD_idx;
            DFO_WB_data <= DFI_PD_RD1;
          end
        end
        default: begin
          if (DMI_ack) begin
            state   <= IDLE;
            DMO_req <= 1'b0;
            if (is_load(uop_q) && (idx_q != '0)) begin
              DFO_WB_en   <= 1'b1;
              DFO_WB_idx  <= idx_q;
              DFO_WB_data <= ld_data;
            end
          end
        end
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DFO_exc      <= 1'b0;
      DFO_exc_addr <= '0;
    end else begin
      DFO_exc <= xfer && mem_op && misal;
      if (xfer && mem_op && misal) DFO_exc_addr <= DFI_PD_RD1[W_AA_DATA-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_mem_writeback.sv
// Randomized self-checking bench for mem_writeback against a behavioural memory-stage model.
module tb_mem_writeback;

  localparam logic [5:0] LB = 6'b101000, LH = 6'b101001, LW = 6'b101010,
                         LBU = 6'b101100, LHU = 6'b101101,
                         SB = 6'b110000, SH = 6'b110001, SW = 6'b110010;

  logic        clk = 1'b0, rst = 1'b1;
  logic        DFI_valid = 1'b0, DFO_ready;
  logic [5:0]  DFI_PD_uops = '0;
  logic [31:0] DFI_PD_RD1 = '0, DFI_PD_rt = '0;
  logic [4:0]  DFI_RD_idx = '0;
  logic        DMO_req, DMO_we;
  logic [31:0] DMO_addr, DMO_wdata;
  logic [3:0]  DMO_be;
  logic        DMI_ack = 1'b0;
  logic [31:0] DMI_rdata = '0;
  logic        DFO_WB_en;
  logic [4:0]  DFO_WB_idx;
  logic [31:0] DFO_WB_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        DFO_exc;
  logic [31:0] DFO_exc_addr;
`endif

  int n_vec = 0, n_bad = 0;

  mem_writeback dut (
    .clk(clk), .rst(rst), .DFI_valid(DFI_valid), .DFO_ready(DFO_ready),
    .DFI_PD_uops(DFI_PD_uops), .DFI_PD_RD1(DFI_PD_RD1), .DFI_PD_rt(DFI_PD_rt),
    .DFI_RD_idx(DFI_RD_idx), .DMO_req(DMO_req), .DMO_we(DMO_we), .DMO_addr(DMO_addr),
    .DMO_be(DMO_be), .DMO_wdata(DMO_wdata), .DMI_ack(DMI_ack), .DMI_rdata(DMI_rdata),
    .DFO_WB_en(DFO_WB_en), .DFO_WB_idx(DFO_WB_idx), .DFO_WB_data(DFO_WB_data)
`ifdef MEM_MISALIGN_TRAP_EN
    , .DFO_exc(DFO_exc), .DFO_exc_addr(DFO_exc_addr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_load(input logic [5:0] u);
    return u == LB || u == LH || u == LW || u == LBU || u == LHU;
  endfunction

  function automatic bit m_store(input logic [5:0] u);
    return u == SB || u == SH || u == SW;
  endfunction

  function automatic bit m_misal(input logic [5:0] u, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    if (u == LH || u == LHU || u == SH) return (a % 2) != 0;
    if (u == LW || u == SW) return (a % 4) != 0;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_ldval(input logic [5:0] u, input logic [31:0] a, input logic [31:0] d);
    int unsigned b, h;
    b = (d >> (8 * (a % 4))) & 32'hFF;
    h = (d >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (u)
      LB:      return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      LBU:     return b;
      LH:      return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      LHU:     return h;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] u, input logic [31:0] a);
    if (u == SB || u == LB || u == LBU) return 4'(1 << (a % 4));
    if (u == SH || u == LH || u == LHU) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] u, input logic [31:0] rt);
    if (u == SB) return (rt & 32'hFF) * 32'h0101_0101;
    if (u == SH) return (rt & 32'hFFFF) * 32'h0001_0001;
    return rt;
  endfunction

  // One uop end to end; lat = extra req cycles before ack, upstream noise while stalled.
  task automatic do_op(input logic [5:0] u, input logic [31:0] a, input logic [31:0] rt,
                       input logic [4:0] idx, input int lat, input logic [31:0] rdat);
    bit ld, st, wb, mis;
    ld  = m_load(u);
    st  = m_store(u);
    mis = (ld || st) && m_misal(u, a);
    check("ready_idle", DFO_ready, 1);
    DFI_valid = 1'b1; DFI_PD_uops = u; DFI_PD_RD1 = a; DFI_PD_rt = rt; DFI_RD_idx = idx;
    @(posedge clk); #1;
    if ((ld || st) && !mis) begin
      for (int i = 0; i <= lat; i++) begin
        check("req_hi", DMO_req, 1);
        check("we", DMO_we, st);
        check("addr", DMO_addr, a & ~32'h3);
        check("ready_busy", DFO_ready, 0);
        check("wb_busy", DFO_WB_en, 0);
        if (st || u == LW) check("be", DMO_be, m_be(u, a));
        if (st) check("wdata", DMO_wdata, m_wdata(u, rt));
        DFI_PD_uops = 6'($urandom); DFI_PD_RD1 = $urandom; DFI_RD_idx = 5'($urandom);
        if (i == lat) begin DMI_ack = 1'b1; DMI_rdata = rdat; end
        @(posedge clk); #1;
      end
      DMI_ack = 1'b0; DFI_valid = 1'b0;
      check("req_drop", DMO_req, 0);
      check("ready_back", DFO_ready, 1);
      wb = ld && (idx != 0);
      check("ld_wb_en", DFO_WB_en, wb);
      if (wb) begin
        check("ld_wb_idx", DFO_WB_idx, idx);
        check("ld_wb_data", DFO_WB_data, m_ldval(u, a, rdat));
      end
    end else begin
      DFI_valid = 1'b0;
      wb = !mis && (u[5:3] <= 3'd2) && (idx != 0);
      check("nm_req", DMO_req, 0);
      check("nm_ready", DFO_ready, 1);
      check("nm_wb_en", DFO_WB_en, wb);
      if (wb) begin
        check("nm_wb_idx", DFO_WB_idx, idx);
        check("nm_wb_data", DFO_WB_data, a);
      end
`ifdef MEM_MISALIGN_TRAP_EN
      check("exc", DFO_exc, mis);
      if (mis) check("exc_addr", DFO_exc_addr, a);
`endif
    end
    @(posedge clk); #1;
    check("wb_pulse", DFO_WB_en, 0);
    check("req_quiet", DMO_req, 0);
  endtask

  task automatic stray_ack();
    DMI_ack = 1'b1; DMI_rdata = $urandom;
    @(posedge clk); #1;
    DMI_ack = 1'b0;
    check("stray_req", DMO_req, 0);
    check("stray_wb", DFO_WB_en, 0);
    check("stray_ready", DFO_ready, 1);
  endtask

  logic [5:0]  ld_codes [5] = '{LB, LH, LW, LBU, LHU};
  logic [5:0]  st_codes [3] = '{SB, SH, SW};
  logic [5:0]  ru;
  logic [31:0] ra;
  logic [4:0]  ri;

  initial begin
    #3;
    check("rst_ready", DFO_ready, 1);
    check("rst_req", DMO_req, 0);
    check("rst_wb_en", DFO_WB_en, 0);
    check("rst_wb_data", DFO_WB_data, 0);
    check("rst_be", DMO_be, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    do_op(6'b000000, 32'h0000_00AB, 32'h0, 5'd5, 0, 32'h0);
    do_op(LW, 32'h100, 32'h0, 5'd7, 2, 32'hDEAD_BEEF);
    do_op(LB, 32'h101, 32'h0, 5'd3, 0, 32'h0000_8000);
    do_op(LBU, 32'h101, 32'h0, 5'd3, 1, 32'h0000_8000);
    do_op(SH, 32'h102, 32'h0000_1234, 5'd9, 0, 32'h0);
    do_op(SB, 32'h203, 32'h0000_00C5, 5'd1, 1, 32'h0);
    do_op(LW, 32'h200, 32'h0, 5'd0, 0, 32'h1234_5678);
    do_op(LH, 32'h302, 32'h0, 5'd4, 0, 32'h9ABC_0000);
    do_op(6'b011_001, 32'h55, 32'h0, 5'd6, 0, 32'h0);
    do_op(6'b100_000, 32'h44, 32'h0, 5'd6, 0, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    do_op(LW, 32'h103, 32'h0, 5'd2, 0, 32'h0);
`else
    do_op(LW, 32'h103, 32'h0, 5'd2, 0, 32'hCAFE_F00D);
`endif

    // Reset in the middle of an outstanding load.
    DFI_valid = 1'b1; DFI_PD_uops = LW; DFI_PD_RD1 = 32'h400; DFI_RD_idx = 5'd8;
    @(posedge clk); #1;
    DFI_valid = 1'b0;
    check("pre_rst_req", DMO_req, 1);
    #2 rst = 1'b1;
    #1;
    check("async_req", DMO_req, 0);
    check("async_ready", DFO_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    stray_ack();
    @(posedge clk); #1;
    check("post_rst_wb", DFO_WB_en, 0);

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    ru = 6'($urandom_range(0, 23));
        2:       ru = 6'(24 + $urandom_range(0, 7));
        3, 4, 5: ru = ld_codes[$urandom_range(0, 4)];
        6, 7:    ru = st_codes[$urandom_range(0, 2)];
        8:       ru = 6'(32 + $urandom_range(0, 7));
        default: ru = 6'(56 + $urandom_range(0, 7));
      endcase
      ra = $urandom;
      ri = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      do_op(ru, ra, $urandom, ri, $urandom_range(0, 4), $urandom);
      if ($urandom_range(0, 5) == 0) stray_ack();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
